// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor control path and datapath.
//
// Contents:
//   - instruction field widths (III XXX YYY format)
//   - opcode constants for mv / mvi / add / sub
//   - control FSM state encoding (T0..T3)
package proc_pkg;

    localparam int IR_W      = 9;
    localparam int OP_W      = 3;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    localparam logic [OP_W-1:0] OP_MV  = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable.
//
// Ports:
//   en     : when low the output is all zeros
//   idx    : register index 0..7
//   onehot : bit idx set when en is high
module dec3to8 (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM for the simple 16-bit processor.
// Decodes the instruction register and drives every bus select and
// register load enable of the datapath, plus the ALU op and done strobe.
//
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   run             : start request, only sampled in T0
//   ir              : instruction [8:6] opcode, [5:3] X, [2:0] Y
//   ir_in           : IR load enable
//   a_in, g_in      : A / G register load enables
//   r_in[7:0]       : R0..R7 load enables (one-hot or zero)
//   imediate_select : bus driven by DIN immediate
//   r_select        : bus driven by G
//   r_out[7:0]      : bus driven by Ri
//   add_sub         : ALU op, 0 = A+bus, 1 = A-bus
//   done            : one-cycle pulse in the last cycle of an instruction
//   busy            : high in any state other than T0
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int IR_WIDTH = IR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [IR_WIDTH-1:0] ir,
    output logic                ir_in,
    output logic                a_in,
    output logic                g_in,
    output logic [7:0]          r_in,
    output logic                imediate_select,
    output logic                r_select,
    output logic [7:0]          r_out,
    output logic                add_sub,
    output logic                done,
    output logic                busy
);

    state_t state;
    state_t next_state;

    logic [OP_W-1:0]      opcode;
    logic [REG_IDX_W-1:0] rx;
    logic [REG_IDX_W-1:0] ry;

    logic                 rin_en;
    logic                 rout_en;
    logic [REG_IDX_W-1:0] rout_idx;

    assign opcode = ir[IR_WIDTH-1 -: OP_W];
    assign rx     = ir[2*REG_IDX_W-1 -: REG_IDX_W];
    assign ry     = ir[REG_IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        ir_in           = 1'b0;
        a_in            = 1'b0;
        g_in            = 1'b0;
        imediate_select = 1'b0;
        r_select        = 1'b0;
        add_sub         = 1'b0;
        done            = 1'b0;
        busy            = (state != T0);
        rin_en          = 1'b0;
        rout_en         = 1'b0;
        rout_idx        = rx;

        case (state)
            T0: begin
                if (run) begin
                    ir_in      = 1'b1;
                    next_state = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        rout_en    = 1'b1;
                        rout_idx   = ry;
                        rin_en     = 1'b1;
                        done       = 1'b1;
                        next_state = T0;
                    end
                    OP_MVI: begin
                        imediate_select = 1'b1;
                        rin_en          = 1'b1;
                        done            = 1'b1;
                        next_state      = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en    = 1'b1;
                        rout_idx   = rx;
                        a_in       = 1'b1;
                        next_state = T2;
                    end
                    default: begin
                        // Reserved opcodes retire as a NOP.
                        done       = 1'b1;
                        next_state = T0;
                    end
                endcase
            end
            T2: begin
                rout_en    = 1'b1;
                rout_idx   = ry;
                g_in       = 1'b1;
                // Low opcode bit distinguishes sub (011) from add (010).
                add_sub    = opcode[0];
                next_state = T3;
            end
            T3: begin
                r_select   = 1'b1;
                rin_en     = 1'b1;
                done       = 1'b1;
                next_state = T0;
            end
            default: begin
                next_state = T0;
            end
        endcase

        // Reset suppresses every enable in the same cycle, so an instruction
        // interrupted mid-flight never writes its destination register.
        if (reset) begin
            ir_in           = 1'b0;
            a_in            = 1'b0;
            g_in            = 1'b0;
            imediate_select = 1'b0;
            r_select        = 1'b0;
            add_sub         = 1'b0;
            done            = 1'b0;
            busy            = 1'b0;
            rin_en          = 1'b0;
            rout_en         = 1'b0;
        end
    end

    dec3to8 u_rin_dec (
        .en     (rin_en),
        .idx    (rx),
        .onehot (r_in)
    );

    dec3to8 u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (r_out)
    );

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit: reset/idle, mv, mvi, add, sub,
// reset mid-instruction, reserved opcode with run held, run toggling.
module tb_proc_control_unit;
    import proc_pkg::*;

    logic       clock;
    logic       reset;
    logic       run;
    logic [8:0] ir;
    logic       ir_in, a_in, g_in, imediate_select, r_select, add_sub, done, busy;
    logic [7:0] r_in, r_out;

    int checks = 0;
    int errors = 0;

    proc_control_unit dut (
        .clock           (clock),
        .reset           (reset),
        .run             (run),
        .ir              (ir),
        .ir_in           (ir_in),
        .a_in            (a_in),
        .g_in            (g_in),
        .r_in            (r_in),
        .imediate_select (imediate_select),
        .r_select        (r_select),
        .r_out           (r_out),
        .add_sub         (add_sub),
        .done            (done),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view: ir_in a_in g_in r_in[8] imm rsel r_out[8] add_sub done busy
    function automatic logic [23:0] ev(input bit e_ir_in, input bit e_a, input bit e_g,
                                       input logic [7:0] e_rin, input bit e_imm,
                                       input bit e_rsel, input logic [7:0] e_rout,
                                       input bit e_as, input bit e_done, input bit e_busy);
        return {e_ir_in, e_a, e_g, e_rin, e_imm, e_rsel, e_rout, e_as, e_done, e_busy};
    endfunction

    task automatic chk(input string tag, input logic [23:0] exp_v);
        logic [23:0] obs;
        obs = {ir_in, a_in, g_in, r_in, imediate_select, r_select, r_out, add_sub, done, busy};
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_bus(input string tag);
        int n;
        n = $countones({imediate_select, r_select, r_out});
        checks++;
        assert (n <= 1)
        else begin
            errors++;
            $error("FAIL %s: observed %0d bus selects expected <= 1", tag, n);
        end
    endtask

    // Advance one clock, then let combinational outputs settle after input changes.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        ir    = '0;

        // Reset held for two cycles
        tick;
        settle; chk("reset_c1", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));
        tick;
        settle; chk("reset_c2", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));

        // Idle with run low
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            settle; chk("idle", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));
        end

        // mvi R5,#D
        ir = {OP_MVI, 3'd5, 3'd0}; run = 1'b1;
        settle; chk("mvi_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b0;
        settle; chk("mvi_t1", ev(0,0,0,8'h20,1,0,8'h00,0,1,1));
        chk_bus("mvi_bus");
        tick;
        settle; chk("mvi_back_t0", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));

        // mv R0,R7
        ir = {OP_MV, 3'd0, 3'd7}; run = 1'b1;
        settle; chk("mv_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b0;
        settle; chk("mv_t1", ev(0,0,0,8'h01,0,0,8'h80,0,1,1));
        chk_bus("mv_bus");
        tick;

        // mv R3,R3 (X==Y)
        ir = {OP_MV, 3'd3, 3'd3}; run = 1'b1;
        settle; chk("mv33_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b0;
        settle; chk("mv33_t1", ev(0,0,0,8'h08,0,0,8'h08,0,1,1));
        tick;

        // sub R2,R6
        ir = {OP_SUB, 3'd2, 3'd6}; run = 1'b1;
        settle; chk("sub_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b0;
        settle; chk("sub_t1", ev(0,1,0,8'h00,0,0,8'h04,0,0,1));
        tick;
        settle; chk("sub_t2", ev(0,0,1,8'h00,0,0,8'h40,1,0,1));
        chk_bus("sub_bus_t2");
        tick;
        settle; chk("sub_t3", ev(0,0,0,8'h04,0,1,8'h00,0,1,1));
        chk_bus("sub_bus_t3");
        tick;
        settle; chk("sub_end", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));

        // add R2,R6
        ir = {OP_ADD, 3'd2, 3'd6}; run = 1'b1;
        settle; chk("add_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b0;
        settle; chk("add_t1", ev(0,1,0,8'h00,0,0,8'h04,0,0,1));
        tick;
        settle; chk("add_t2", ev(0,0,1,8'h00,0,0,8'h40,0,0,1));
        tick;
        settle; chk("add_t3", ev(0,0,0,8'h04,0,1,8'h00,0,1,1));
        tick;

        // add R1,R3 interrupted by reset in T2
        ir = {OP_ADD, 3'd1, 3'd3}; run = 1'b1;
        settle; chk("rmid_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b0;
        settle; chk("rmid_t1", ev(0,1,0,8'h00,0,0,8'h02,0,0,1));
        tick; reset = 1'b1;
        settle; chk("rmid_t2_reset", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; reset = 1'b0;
        settle; chk("rmid_after", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));
        ir = {OP_MVI, 3'd5, 3'd0}; run = 1'b1;
        settle; chk("rmid_mvi_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b0;
        settle; chk("rmid_mvi_t1", ev(0,0,0,8'h20,1,0,8'h00,0,1,1));
        tick;

        // Reserved opcode with run held high
        ir = 9'b111_000_000; run = 1'b1;
        settle; chk("nop_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick;
        settle; chk("nop_t1", ev(0,0,0,8'h00,0,0,8'h00,0,1,1));
        tick;
        settle; chk("nop_refetch", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick;
        settle; chk("nop_t1b", ev(0,0,0,8'h00,0,0,8'h00,0,1,1));
        tick;

        // add R3,R4 with run toggling during execution
        ir = {OP_ADD, 3'd3, 3'd4}; run = 1'b1;
        settle; chk("tog_t0", ev(1,0,0,8'h00,0,0,8'h00,0,0,0));
        tick; run = 1'b1;
        settle; chk("tog_t1", ev(0,1,0,8'h00,0,0,8'h08,0,0,1));
        tick; run = 1'b0;
        settle; chk("tog_t2", ev(0,0,1,8'h00,0,0,8'h10,0,0,1));
        tick; run = 1'b1;
        settle; chk("tog_t3", ev(0,0,0,8'h08,0,1,8'h00,0,1,1));
        tick; run = 1'b0;
        settle; chk("tog_end", ev(0,0,0,8'h00,0,0,8'h00,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
